// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired CPU control sequencer:
// state encoding, opcode values, IR field positions and opcode classification.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU3   = 3'd1,
    CLS_MULDIV = 3'd2,
    CLS_UNARY  = 3'd3,
    CLS_HALT   = 3'd4
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // ALU3 is a contiguous opcode range (ADD..SHL, ROL included).
  function automatic op_class_t op_class(input logic [4:0] opc);
    op_class_t cls;
    cls = CLS_NOP;
    if (opc >= OP_ADD && opc <= OP_SHL) begin
      cls = CLS_ALU3;
    end else if (opc == OP_DIV || opc == OP_MUL) begin
      cls = CLS_MULDIV;
    end else if (opc == OP_NEG || opc == OP_NOT) begin
      cls = CLS_UNARY;
    end else if (opc == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// Converts a 4-bit register field into a one-hot enable vector, gated by en.
module reg_select_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot[gi] = en && (32'(sel) == gi);
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode, and execute sequencing for
// ALU3, MUL/DIV and NEG/NOT instructions; Moore strobes for the datapath.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_rdy,
  input  logic                stop,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                read,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_high_in,
  output logic                z_low_in,
  output logic                z_high_out,
  output logic                z_low_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [4:0]          alu_op,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                run,
  output logic [3:0]          state
);

  state_t     state_reg;
  state_t     state_next;
  op_class_t  cls;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       reg_in_en;
  logic       reg_out_en;
  logic [3:0] reg_out_sel;
  logic       unused_ir;

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign ra        = ir[RA_MSB:RA_LSB];
  assign rb        = ir[RB_MSB:RB_LSB];
  assign rc        = ir[RC_MSB:RC_LSB];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[RC_LSB-1:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= ST_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  // Execute states fall back to T0 if the class does not expect them.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RST:  state_next = ST_T0;
      ST_T0:   state_next = stop ? ST_HALT : ST_T1;
      ST_T1:   state_next = mem_rdy ? ST_T2 : ST_T1;
      ST_T2: begin
        case (cls)
          CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_next = ST_T3;
          CLS_HALT:                        state_next = ST_HALT;
          default:                         state_next = ST_T0;
        endcase
      end
      ST_T3:   state_next = (cls == CLS_NOP || cls == CLS_HALT) ? ST_T0 : ST_T4;
      ST_T4:   state_next = (cls == CLS_ALU3 || cls == CLS_MULDIV) ? ST_T5 : ST_T0;
      ST_T5:   state_next = (cls == CLS_MULDIV) ? ST_T6 : ST_T0;
      ST_T6:   state_next = ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  always_comb begin
    pc_out      = 1'b0;
    pc_in       = 1'b0;
    inc_pc      = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    read        = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    z_high_in   = 1'b0;
    z_low_in    = 1'b0;
    z_high_out  = 1'b0;
    z_low_out   = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    alu_op      = 5'b00000;
    reg_in_en   = 1'b0;
    reg_out_en  = 1'b0;
    reg_out_sel = rb;
    case (state_reg)
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        pc_in  = 1'b1;
      end
      ST_T1: begin
        read   = 1'b1;
        mdr_in = 1'b1;
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        if (cls == CLS_ALU3 || cls == CLS_MULDIV) begin
          reg_out_en  = 1'b1;
          reg_out_sel = rc;
          y_in        = 1'b1;
        end else if (cls == CLS_UNARY) begin
          reg_out_en = 1'b1;
          alu_op     = opcode;
          z_low_in   = 1'b1;
        end
      end
      ST_T4: begin
        if (cls == CLS_ALU3 || cls == CLS_MULDIV) begin
          reg_out_en = 1'b1;
          alu_op     = opcode;
          z_low_in   = 1'b1;
          z_high_in  = (cls == CLS_MULDIV);
        end else if (cls == CLS_UNARY) begin
          z_low_out = 1'b1;
          reg_in_en = 1'b1;
        end
      end
      ST_T5: begin
        if (cls == CLS_ALU3) begin
          z_low_out = 1'b1;
          reg_in_en = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          z_low_out = 1'b1;
          lo_in     = 1'b1;
        end
      end
      ST_T6: begin
        if (cls == CLS_MULDIV) begin
          z_high_out = 1'b1;
          hi_in      = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign run   = (state_reg != ST_RST) && (state_reg != ST_HALT);
  assign state = state_reg;

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_reg_in_dec (
    .sel    (ra),
    .en     (reg_in_en),
    .onehot (reg_in)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_reg_out_dec (
    .sel    (reg_out_sel),
    .en     (reg_out_en),
    .onehot (reg_out)
  );

endmodule
